led_mode_sequencer: RTL and testbench

Controller that drives the 2-bit pattern-select and blink-phase inputs of the three-LED pattern block. It turns two raw push-buttons into a manual/automatic mode scheduler: manual mode steps the pattern on each press, automatic mode steps it on every prescaler tick. It sits between the board buttons and the LED pattern datapath, and owns the only blink timebase in the design.

---
 rtl/led_mode_sequencer_pkg.sv | 24 ++
 rtl/led_mode_sequencer_btn_conditioner.sv | 81 ++++++++
 rtl/led_mode_sequencer.sv | 97 +++++++++
 tb/tb_led_mode_sequencer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/led_mode_sequencer_pkg.sv
// Shared types and reset constants for the LED mode sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: pattern-select width, scheduler state enum, reset values of the
// registered outputs, and the wrapping mode increment.
package led_pkg;

  localparam int MODE_W = 2;

  typedef enum logic {
    S_MANUAL = 1'b0,
    S_AUTO   = 1'b1
  } state_t;

  localparam logic [MODE_W-1:0] MODE_RST  = 2'd0;
  localparam logic              BLINK_RST = 1'b1;

  // 3 rolls over to 0 through natural modular arithmetic.
  function automatic logic [MODE_W-1:0] mode_inc(input logic [MODE_W-1:0] m);
    return m + MODE_W'(1);
  endfunction

endpackage

// File: rtl/led_mode_sequencer_btn_conditioner.sv
// Turns one raw push-button into a single-cycle press pulse.
// Latency: raw rise to press = 2 cycles, plus DEB_CYC cycles with DEBOUNCE_EN.
// Backpressure: none; every accepted rising edge emits exactly one pulse.
//
// Ports: CLK, RST_N (async active-low), btn (raw, asynchronous, active-high),
//        press (registered one-cycle pulse on the accepted level's rising edge).
// Build option: define DEBOUNCE_EN to add the DEB_CYC stability filter;
//               without it the synchronized level is used directly.
module btn_conditioner #(
  parameter int DEB_CYC = 500000
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic btn,
  output logic press
);

  logic s1;
  logic s2;
  logic level;
  logic level_nxt;
  logic fill1;
  logic fill2;
  logic armed;

`ifdef DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEB_CYC + 1);

  logic [CNT_W-1:0] stab_cnt;
  logic             flip;

  // Flip on the cycle that completes DEB_CYC consecutive mismatches.
  assign flip      = (s2 != level) && (stab_cnt == CNT_W'(DEB_CYC - 1));
  assign level_nxt = flip ? s2 : level;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      stab_cnt <= '0;
      level    <= 1'b0;
    end else if (s2 == level) begin
      stab_cnt <= '0;
    end else if (flip) begin
      stab_cnt <= '0;
      level    <= s2;
    end else begin
      stab_cnt <= stab_cnt + CNT_W'(1);
    end
  end
`else
  logic unused_deb;

  assign unused_deb = (DEB_CYC > 0);
  assign level      = s2;
  assign level_nxt  = s1;
`endif

  // fill1/fill2 mark when s2 carries a real sample instead of its reset
  // value. The edge detector stays disarmed until the button has genuinely
  // been seen released, so a button held across reset release is ignored.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      fill1 <= 1'b0;
      fill2 <= 1'b0;
      armed <= 1'b0;
      press <= 1'b0;
    end else begin
      s1    <= btn;
      s2    <= s1;
      fill1 <= 1'b1;
      fill2 <= fill1;
      if (fill2 && !s2) begin
        armed <= 1'b1;
      end
      // Pulse is captured on the same edge that raises the accepted level.
      press <= armed && level_nxt && !level;
    end
  end

endmodule

// File: rtl/led_mode_sequencer.sv
// Manual/automatic pattern scheduler and blink timebase for the LED block.
// Latency: raw button rise to mode change DEB_CYC+3 cycles (3 without debounce).
// Backpressure: none; the LED block consumes mode/blink every cycle.
//
// Ports: CLK, RST_N (async active-low); btn_next, btn_auto raw buttons;
//        mode[1:0] pattern select, blink phase, tick wrap pulse, auto_on
//        state flag -- all registered.
// Build option: DEBOUNCE_EN enables the button stability filter.
module led_mode_sequencer
  import led_pkg::*;
#(
  parameter int TICK_DIV = 25000000,
  parameter int DEB_CYC  = 500000
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              btn_next,
  input  logic              btn_auto,
  output logic [MODE_W-1:0] mode,
  output logic              blink,
  output logic              tick,
  output logic              auto_on
);

  localparam int PRE_W = $clog2(TICK_DIV);

  logic [PRE_W-1:0] pre_cnt;
  logic             wrap;
  logic             next_press;
  logic             auto_press;
  state_t           state;

  btn_conditioner #(.DEB_CYC(DEB_CYC)) u_cond_next (
    .CLK   (CLK),
    .RST_N (RST_N),
    .btn   (btn_next),
    .press (next_press)
  );

  btn_conditioner #(.DEB_CYC(DEB_CYC)) u_cond_auto (
    .CLK   (CLK),
    .RST_N (RST_N),
    .btn   (btn_auto),
    .press (auto_press)
  );

  assign wrap = (pre_cnt == PRE_W'(TICK_DIV - 1));

  // Free-running timebase, never restarted by mode changes.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pre_cnt <= '0;
      tick    <= 1'b0;
      blink   <= BLINK_RST;
    end else begin
      pre_cnt <= wrap ? '0 : pre_cnt + PRE_W'(1);
      tick    <= wrap;
      if (wrap) begin
        blink <= ~blink;
      end
    end
  end

  // auto_press takes priority and always leaves mode untouched; in S_AUTO a
  // coincident wrap and next_press fold into one increment.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= S_MANUAL;
      mode    <= MODE_RST;
      auto_on <= 1'b0;
    end else begin
      case (state)
        S_MANUAL: begin
          if (auto_press) begin
            state   <= S_AUTO;
            auto_on <= 1'b1;
          end else if (next_press) begin
            mode <= mode_inc(mode);
          end
        end
        S_AUTO: begin
          if (auto_press) begin
            state   <= S_MANUAL;
            auto_on <= 1'b0;
          end else if (next_press || wrap) begin
            mode <= mode_inc(mode);
          end
        end
        default: begin
          state   <= S_MANUAL;
          auto_on <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_mode_sequencer.sv
// Directed bench for led_mode_sequencer with TICK_DIV=8, DEB_CYC=4.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_led_mode_sequencer;

  localparam int TICK_DIV = 8;
  localparam int DEB_CYC  = 4;
`ifdef DEBOUNCE_EN
  localparam int LAT         = DEB_CYC + 3;
  localparam int BOUNCE_PRE  = 0;
  localparam int BOUNCE_POST = 1;
`else
  localparam int LAT         = 3;
  localparam int BOUNCE_PRE  = 3;
  localparam int BOUNCE_POST = 4;
`endif

  logic       CLK;
  logic       RST_N;
  logic       btn_next;
  logic       btn_auto;
  logic [1:0] mode;
  logic       blink;
  logic       tick;
  logic       auto_on;

  int         checks;
  int         failures;
  int         ecnt;
  logic [1:0] exp_mode;
  logic [1:0] tmp_mode;

  led_mode_sequencer #(.TICK_DIV(TICK_DIV), .DEB_CYC(DEB_CYC)) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .btn_next (btn_next),
    .btn_auto (btn_auto),
    .mode     (mode),
    .blink    (blink),
    .tick     (tick),
    .auto_on  (auto_on)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference timebase: rising edges seen since reset release.
  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) ecnt <= 0;
    else        ecnt <= ecnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock, then check tick/blink against the reference timebase.
  task automatic step();
    @(posedge CLK);
    #1;
    chk("tick_model", tick, (ecnt != 0 && (ecnt % TICK_DIV) == 0));
    chk("blink_model", blink, 1 ^ ((ecnt / TICK_DIV) % 2));
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Step while in S_AUTO: mode advances on every wrap.
  task automatic auto_step();
    step();
    if ((ecnt % TICK_DIV) == 0) exp_mode = exp_mode + 2'd1;
    chk("auto_mode", mode, exp_mode);
  endtask

  task automatic run_auto(input int n);
    for (int i = 0; i < n; i++) auto_step();
  endtask

  task automatic auto_until(input int ph);
    for (int k = 0; k < TICK_DIV && (ecnt % TICK_DIV) != ph; k++) auto_step();
  endtask

  task automatic manual_until(input int ph);
    for (int k = 0; k < TICK_DIV && (ecnt % TICK_DIV) != ph; k++) step();
  endtask

  // Clean btn_next press held 10 cycles in S_MANUAL.
  task automatic press_next(input string tag);
    btn_next = 1'b1;
    steps(LAT - 1);
    chk({tag, "_before"}, mode, exp_mode);
    step();
    exp_mode = exp_mode + 2'd1;
    chk(tag, mode, exp_mode);
    steps(10 - LAT);
    btn_next = 1'b0;
    steps(12);
    chk({tag, "_hold"}, mode, exp_mode);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    exp_mode = 2'd0;
    RST_N    = 1'b0;
    btn_next = 1'b0;
    btn_auto = 1'b0;

    // Reset held with buttons toggling.
    for (int i = 0; i < 6; i++) begin
      btn_next = i[0];
      btn_auto = ~i[0];
      step();
      chk("rst_mode", mode, 0);
      chk("rst_tick", tick, 0);
      chk("rst_blink", blink, 1);
      chk("rst_auto_on", auto_on, 0);
    end
    RST_N    = 1'b1;
    btn_next = 1'b0;
    btn_auto = 1'b0;
    steps(TICK_DIV - 1);
    chk("first_tick_early", tick, 0);
    step();
    chk("first_tick", tick, 1);
    chk("first_blink", blink, 0);

    // Manual stepping 1,2,3,0.
    press_next("man1");
    press_next("man2");
    press_next("man3");
    press_next("man0");
    chk("man_wrap", mode, 0);

    // Bounce: 3 short pulses, then held high.
    for (int i = 0; i < 3; i++) begin
      btn_next = 1'b1;
      steps(2);
      btn_next = 1'b0;
      steps(2);
    end
    btn_next = 1'b1;
    steps(LAT - 1);
    tmp_mode = exp_mode + 2'(BOUNCE_PRE);
    chk("bounce_before", mode, tmp_mode);
    step();
    exp_mode = exp_mode + 2'(BOUNCE_POST);
    chk("bounce_after", mode, exp_mode);
    steps(3);
    btn_next = 1'b0;
    steps(12);
    chk("bounce_hold", mode, exp_mode);

    // Enter auto mode.
    btn_auto = 1'b1;
    steps(LAT - 1);
    chk("auto_enter_before", auto_on, 0);
    step();
    chk("auto_enter", auto_on, 1);
    chk("auto_enter_mode", mode, exp_mode);
    btn_auto = 1'b0;
    for (int i = 0; i < 4; i++) begin
      auto_until(TICK_DIV - 1);
      step();
      exp_mode = exp_mode + 2'd1;
      chk("auto_tick_mode", mode, exp_mode);
      chk("auto_tick", tick, 1);
    end

    // Leave auto mode on the same edge as a wrap: mode must not step.
    auto_until((TICK_DIV - LAT) % TICK_DIV);
    btn_auto = 1'b1;
    steps(LAT - 1);
    chk("auto_exit_before", auto_on, 1);
    chk("auto_exit_before_mode", mode, exp_mode);
    step();
    chk("auto_exit", auto_on, 0);
    chk("auto_exit_tick", tick, 1);
    chk("auto_exit_mode", mode, exp_mode);
    btn_auto = 1'b0;
    steps(2 * TICK_DIV);
    chk("frozen_mode", mode, exp_mode);
    chk("frozen_auto_on", auto_on, 0);

    // Both buttons at once in S_MANUAL: go auto, drop the step.
    manual_until(2);
    btn_next = 1'b1;
    btn_auto = 1'b1;
    steps(LAT);
    chk("both_auto_on", auto_on, 1);
    chk("both_mode", mode, exp_mode);
    btn_next = 1'b0;
    btn_auto = 1'b0;
    run_auto(12);

    // next_press aligned with a wrap in S_AUTO: single increment.
    auto_until((TICK_DIV - LAT) % TICK_DIV);
    btn_next = 1'b1;
    steps(LAT - 1);
    chk("coll_before", mode, exp_mode);
    step();
    chk("coll_tick", tick, 1);
    exp_mode = exp_mode + 2'd1;
    chk("coll_single_inc", mode, exp_mode);
    btn_next = 1'b0;
    run_auto(12);

    // Run to mode 2 in S_AUTO, then reset asynchronously.
    for (int k = 0; k < 4 * TICK_DIV && exp_mode != 2'd2; k++) auto_step();
    chk("pre_reset_mode", mode, 2);
    chk("pre_reset_auto_on", auto_on, 1);
    btn_next = 1'b1;
    RST_N    = 1'b0;
    #1;
    chk("async_rst_mode", mode, 0);
    chk("async_rst_tick", tick, 0);
    chk("async_rst_blink", blink, 1);
    chk("async_rst_auto_on", auto_on, 0);
    exp_mode = 2'd0;
    steps(3);
    RST_N = 1'b1;
    steps(20);
    chk("held_through_reset", mode, 0);
    chk("held_auto_on", auto_on, 0);
    btn_next = 1'b0;
    steps(12);
    press_next("repress");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
